// File: rtl/id_scan_ctrl.sv
// Flow-controlled identifier scanner: classifies streamed ASCII characters and queues
// {start, len, trunc} token records in a first-word-fall-through FIFO. Optional macro ID_UNDERSCORE_EN treats '_' as a letter.
module id_scan_ctrl #(
   parameter int POS_W      = 16,
   parameter int LEN_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   input  logic             in_last,
   output logic             tok_valid,
   input  logic             tok_ready,
   output logic [POS_W-1:0] tok_start,
   output logic [LEN_W-1:0] tok_len,
   output logic             tok_trunc,
   output logic [15:0]      id_count,
   output logic             busy
);
   // state  | meaning
   // S_GAP  | between tokens, waiting for a letter
   // S_ID   | inside an identifier, accumulating length
   // S_SKIP | inside a digit-led run, discarded at next delimiter
   typedef enum logic [1:0] {S_GAP, S_ID, S_SKIP} state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   state_t state, state_nxt;
   logic [POS_W-1:0] pos, run_start, run_start_nxt;
   logic [LEN_W-1:0] run_len, run_len_nxt, ext_len;
   logic             run_trunc, run_trunc_nxt, ext_trunc;
   logic             accept, is_letter, is_digit;
   logic             push, pop, fifo_full, fifo_empty;
   logic [POS_W-1:0] push_start;
   logic [LEN_W-1:0] push_len;
   logic             push_trunc;
   logic [AW:0]      wr_ptr, rd_ptr;
   logic [POS_W-1:0] mem_start [FIFO_DEPTH];
   logic [LEN_W-1:0] mem_len   [FIFO_DEPTH];
   logic             mem_trunc [FIFO_DEPTH];

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready   = !fifo_full;
   assign accept     = in_valid && in_ready;
   assign tok_valid  = !fifo_empty;
   assign pop        = tok_valid && tok_ready;
   assign tok_start  = mem_start[rd_ptr[AW-1:0]];
   assign tok_len    = mem_len[rd_ptr[AW-1:0]];
   assign tok_trunc  = mem_trunc[rd_ptr[AW-1:0]];
   assign busy       = (state != S_GAP) || !fifo_empty;

   always_comb begin
      is_digit  = (in_char >= 8'h30) && (in_char <= 8'h39);
      is_letter = ((in_char >= 8'h41) && (in_char <= 8'h5A)) ||
                  ((in_char >= 8'h61) && (in_char <= 8'h7A));
`ifdef ID_UNDERSCORE_EN
      if (in_char == 8'h5F) is_letter = 1'b1;
`endif
   end

   // Extending a run already at LEN_MAX keeps the length and flags truncation.
   assign ext_len   = (run_len == LEN_MAX) ? run_len : run_len + LEN_W'(1);
   assign ext_trunc = run_trunc || (run_len == LEN_MAX);

   always_comb begin
      state_nxt     = state;
      run_start_nxt = run_start;
      run_len_nxt   = run_len;
      run_trunc_nxt = run_trunc;
      push          = 1'b0;
      push_start    = run_start;
      push_len      = run_len;
      push_trunc    = run_trunc;
      if (accept) begin
         case (state)
            S_GAP: begin
               if (is_letter) begin
                  run_start_nxt = pos;
                  run_len_nxt   = LEN_W'(1);
                  run_trunc_nxt = 1'b0;
                  if (in_last) begin
                     push       = 1'b1;
                     push_start = pos;
                     push_len   = LEN_W'(1);
                     push_trunc = 1'b0;
                     state_nxt  = S_GAP;
                  end else begin
                     state_nxt  = S_ID;
                  end
               end else if (is_digit) begin
                  state_nxt = in_last ? S_GAP : S_SKIP;
               end
            end
            S_ID: begin
               if (is_letter || is_digit) begin
                  run_len_nxt   = ext_len;
                  run_trunc_nxt = ext_trunc;
                  if (in_last) begin
                     push       = 1'b1;
                     push_len   = ext_len;
                     push_trunc = ext_trunc;
                     state_nxt  = S_GAP;
                  end
               end else begin
                  push      = 1'b1;
                  state_nxt = S_GAP;
               end
            end
            S_SKIP: begin
               if (in_last || !(is_letter || is_digit)) state_nxt = S_GAP;
            end
            default: state_nxt = S_GAP;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_GAP;
         pos       <= '0;
         run_start <= '0;
         run_len   <= '0;
         run_trunc <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         id_count  <= '0;
      end else begin
         state     <= state_nxt;
         run_start <= run_start_nxt;
         run_len   <= run_len_nxt;
         run_trunc <= run_trunc_nxt;
         if (accept) pos <= in_last ? '0 : pos + POS_W'(1);
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
            if (id_count != 16'hFFFF) id_count <= id_count + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_start[wr_ptr[AW-1:0]] <= push_start;
         mem_len[wr_ptr[AW-1:0]]   <= push_len;
         mem_trunc[wr_ptr[AW-1:0]] <= push_trunc;
      end
   end
endmodule

// File: tb/tb_id_scan_ctrl.sv
// Directed bench for id_scan_ctrl: default instance plus a LEN_W=3 instance for saturation.
module tb_id_scan_ctrl;
   typedef struct packed {logic [15:0] s; logic [7:0] l; logic t;} tok_t;

   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, tok_ready = 1'b0;
   logic [7:0] in_char = 8'h00;
   logic in_ready, tok_valid, tok_trunc, busy;
   logic [15:0] tok_start, id_count;
   logic [7:0] tok_len;
   logic in_ready3, tok_valid3, tok_trunc3, busy3;
   logic [15:0] tok_start3, id_count3;
   logic [2:0] tok_len3;

   int total = 0, bad = 0;
   tok_t q[$];
   tok_t g;

   id_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_char(in_char), .in_last(in_last), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_start(tok_start), .tok_len(tok_len), .tok_trunc(tok_trunc),
      .id_count(id_count), .busy(busy));

   id_scan_ctrl #(.LEN_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .in_char(in_char), .in_last(in_last), .tok_valid(tok_valid3), .tok_ready(tok_ready),
      .tok_start(tok_start3), .tok_len(tok_len3), .tok_trunc(tok_trunc3),
      .id_count(id_count3), .busy(busy3));

   always #5 clk = ~clk;

   // Record every handshake-completed token of the default instance.
   always @(posedge clk)
      if (rst_n && tok_valid && tok_ready) q.push_back({tok_start, tok_len, tok_trunc});

   function automatic tok_t get_tok(input int i);
      if (i < q.size()) return q[i];
      return '1;
   endfunction

   task automatic send(input logic [7:0] c, input logic last);
      int n = 0;
      in_valid = 1'b1; in_char = c; in_last = last;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL send_timeout char=%h in_ready=%b required 1", c, in_ready);
         in_valid = 1'b0; in_last = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (in_ready !== 1'b1 || tok_valid !== 1'b0 || id_count !== 16'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got ready=%b valid=%b count=%0d busy=%b want 1 0 0 0",
                  in_ready, tok_valid, id_count, busy);
      end
   endtask

   task automatic test_basic();
      do_reset();
      tok_ready = 1'b1;
      send_str("ab");
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
      send_str("1 ");
      total++;
      if (tok_valid !== 1'b1 || tok_start !== 16'd0 || tok_len !== 8'd3) begin
         bad++;
         $display("FAIL basic_latency got valid=%b start=%0d len=%0d want 1 0 3", tok_valid, tok_start, tok_len);
      end
      send_str("x ");
      repeat (3) @(negedge clk);
      total++;
      if (q.size() != 2) begin bad++; $display("FAIL basic_count got=%0d want=2", q.size()); end
      g = get_tok(0); total++;
      if (g !== tok_t'({16'd0, 8'd3, 1'b0})) begin
         bad++; $display("FAIL basic_tok0 got start=%0d len=%0d trunc=%0d want 0 3 0", g.s, g.l, g.t);
      end
      g = get_tok(1); total++;
      if (g !== tok_t'({16'd4, 8'd1, 1'b0})) begin
         bad++; $display("FAIL basic_tok1 got start=%0d len=%0d trunc=%0d want 4 1 0", g.s, g.l, g.t);
      end
      total++;
      if (id_count !== 16'd2 || busy !== 1'b0) begin
         bad++; $display("FAIL basic_idcount got count=%0d busy=%b want 2 0", id_count, busy);
      end
   endtask

   task automatic test_skip();
      do_reset();
      tok_ready = 1'b1;
      send_str("9abc;a9;");
      repeat (3) @(negedge clk);
      g = get_tok(0); total++;
      if (q.size() != 1 || g !== tok_t'({16'd5, 8'd2, 1'b0})) begin
         bad++;
         $display("FAIL skip_tok got n=%0d start=%0d len=%0d trunc=%0d want 1 5 2 0", q.size(), g.s, g.l, g.t);
      end
      total++;
      if (id_count !== 16'd1) begin bad++; $display("FAIL skip_idcount got=%0d want=1", id_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      tok_ready = 1'b0;
      send_str("a;b;c;d;");
      total++;
      if (in_ready !== 1'b0 || tok_valid !== 1'b1 || tok_start !== 16'd0) begin
         bad++;
         $display("FAIL bp_full got ready=%b valid=%b start=%0d want 0 1 0", in_ready, tok_valid, tok_start);
      end
      in_valid = 1'b1; in_char = "e";
      repeat (3) @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || tok_start !== 16'd0 || tok_len !== 8'd1 || id_count !== 16'd4) begin
         bad++;
         $display("FAIL bp_hold got ready=%b start=%0d len=%0d count=%0d want 0 0 1 4",
                  in_ready, tok_start, tok_len, id_count);
      end
      tok_ready = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_reraise got=%b want=1", in_ready); end
      send("e", 1'b0);
      send(";", 1'b0);
      repeat (4) @(negedge clk);
      total++;
      if (q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5", q.size()); end
      for (int i = 0; i < 5; i++) begin
         g = get_tok(i); total++;
         if (g !== tok_t'({16'(2 * i), 8'd1, 1'b0})) begin
            bad++;
            $display("FAIL bp_tok%0d got start=%0d len=%0d want %0d 1", i, g.s, g.l, 2 * i);
         end
      end
      total++;
      if (id_count !== 16'd5) begin bad++; $display("FAIL bp_idcount got=%0d want=5", id_count); end
   endtask

   task automatic test_trunc();
      do_reset();
      tok_ready = 1'b1;
      send_str("abcdefghij;");
      total++;
      if (tok_valid3 !== 1'b1 || tok_start3 !== 16'd0 || tok_len3 !== 3'd7 || tok_trunc3 !== 1'b1) begin
         bad++;
         $display("FAIL trunc_len3 got valid=%b start=%0d len=%0d trunc=%b want 1 0 7 1",
                  tok_valid3, tok_start3, tok_len3, tok_trunc3);
      end
      total++;
      if (tok_valid !== 1'b1 || tok_len !== 8'd10 || tok_trunc !== 1'b0) begin
         bad++;
         $display("FAIL trunc_len8 got valid=%b len=%0d trunc=%b want 1 10 0", tok_valid, tok_len, tok_trunc);
      end
   endtask

   task automatic test_last();
      do_reset();
      tok_ready = 1'b1;
      send("a", 1'b0);
      send("b", 1'b1);
      total++;
      if (tok_valid !== 1'b1 || tok_start !== 16'd0 || tok_len !== 8'd2 || busy !== 1'b1) begin
         bad++;
         $display("FAIL last_push got valid=%b start=%0d len=%0d busy=%b want 1 0 2 1",
                  tok_valid, tok_start, tok_len, busy);
      end
      send_str("c;");
      repeat (3) @(negedge clk);
      g = get_tok(1); total++;
      if (q.size() != 2 || g !== tok_t'({16'd0, 8'd1, 1'b0})) begin
         bad++;
         $display("FAIL last_pos_reset got n=%0d start=%0d len=%0d want 2 0 1", q.size(), g.s, g.l);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      tok_ready = 1'b1;
      send_str("abc");
      rst_n = 1'b0;
      #1;
      total++;
      if (tok_valid !== 1'b0 || busy !== 1'b0 || id_count !== 16'd0) begin
         bad++;
         $display("FAIL rstmid_async got valid=%b busy=%b count=%0d want 0 0 0", tok_valid, busy, id_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      send_str("x;");
      repeat (3) @(negedge clk);
      g = get_tok(0); total++;
      if (q.size() != 1 || g !== tok_t'({16'd0, 8'd1, 1'b0})) begin
         bad++;
         $display("FAIL rstmid_tok got n=%0d start=%0d len=%0d want 1 0 1", q.size(), g.s, g.l);
      end
   endtask

   task automatic test_underscore();
      tok_t exp;
`ifdef ID_UNDERSCORE_EN
      exp = {16'd0, 8'd3, 1'b0};
`else
      exp = {16'd1, 8'd2, 1'b0};
`endif
      do_reset();
      tok_ready = 1'b1;
      send_str("_a1;");
      repeat (3) @(negedge clk);
      g = get_tok(0); total++;
      if (q.size() != 1 || g !== exp) begin
         bad++;
         $display("FAIL underscore got n=%0d start=%0d len=%0d want 1 %0d %0d", q.size(), g.s, g.l, exp.s, exp.l);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skip();
      test_back_to_back();
      test_trunc();
      test_last();
      test_reset_mid();
      test_underscore();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/id_scan_ctrl.md
Name: id_scan_ctrl

Overview:
- Streaming identifier scanner/controller: accepts ASCII characters over a valid/ready handshake, tracks character position, and recognises identifiers (a letter followed by letters or digits).
- For each completed identifier it queues a token record (start position, length) in a small FIFO, drained over a second valid/ready handshake.
- Sits between the character source (UART/ROM reader) and downstream token consumers; replaces the free-running per-cycle recogniser with a flow-controlled one.

Parameters:
- POS_W, 16, width of character position counter and tok_start.
- LEN_W, 8, width of tok_len; length saturates at 2^LEN_W-1.
- FIFO_DEPTH, 4, token FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_char valid.
- in_ready  out  1  scanner can accept a char.
- in_char  in  8  ASCII character.
- in_last  in  1  accepted char is last of its stream.
- tok_valid  out  1  FIFO head valid.
- tok_ready  in  1  consumer takes head.
- tok_start  out  POS_W  position of the identifier's first char.
- tok_len  out  LEN_W  identifier length (saturated).
- tok_trunc  out  1  length saturated.
- id_count  out  16  identifiers queued since reset, saturating at 16'hFFFF.
- busy  out  1  state != S_GAP or FIFO not empty.

Behaviour:
- Reset (async, rst_n=0): state S_GAP, pos=0, run length=0, FIFO empty, tok_valid=0, id_count=0, busy=0. in_ready=1 once reset is released. A partial token is discarded on reset.
- Accept = in_valid && in_ready on a rising clk edge.
- in_ready = !fifo_full. This is combinational from registered state only and does not depend on in_valid.
- Classes:
  - letter = 8'h41..8'h5A or 8'h61..8'h7A.
  - digit = 8'h30..8'h39.
  - everything else = delimiter.
- pos increments on every accept and wraps mod 2^POS_W. An accept with in_last=1 sets pos=0 for the next char.
- States (advance only on accept):
  - S_GAP: letter -> S_ID (start=pos, len=1); digit -> S_SKIP; delim -> S_GAP.
  - S_ID: letter/digit -> S_ID (len+1, saturating; set trunc on saturation); delim -> push {start,len,trunc}, S_GAP.
  - S_SKIP (digit-led run, never a token): letter/digit -> S_SKIP; delim -> S_GAP.
- in_last handling, applied to the accepted char:
  - If the char ends or extends an identifier (state S_ID with letter/digit, or S_GAP with letter), the identifier including that char is pushed.
  - Next state is always S_GAP.
- Push precedence: a push happens at most once per accept. in_ready=0 when full, so no push is lost.
- FIFO is first-word-fall-through. tok_* is valid the cycle after the terminating char is accepted (latency 1).
- Pop on tok_valid && tok_ready. tok_* are stable while tok_valid=1 and tok_ready=0.
- Simultaneous push and pop: allowed; occupancy unchanged.
- A pop while full re-raises in_ready in the following cycle.
- id_count increments on each push and holds at 16'hFFFF.

Optional Feature:
- ID_UNDERSCORE_EN defined: '_' (8'h5F) is classed as a letter in all states. It may start an identifier or appear inside one.
- ID_UNDERSCORE_EN undefined: '_' is a delimiter.

Test Plan:
- "ab1 x" (8'h20 delims), tok_ready=1, pos starts 0 -> tokens {start=0,len=3}, {start=4,len=1}; id_count=2.
- "9abc;" -> no token (S_SKIP); "a9;" -> {0? no: start=5,len=2} with position continuing from 5.
- tok_ready=0, stream "a;b;c;d;e;" -> 4 tokens queued, in_ready=0 at the 5th terminator pending. Raise tok_ready -> tokens popped in order, starts 0,2,4,6 then 8; no loss.
- LEN_W=3, "abcdefghij;" -> {start=0,len=7,trunc=1}.
- "ab" with in_last on 'b' -> {0,2} pushed; next char 'c'+';' -> {start=0,len=1} (pos reset).
- rst_n low mid-identifier "abc" then release -> FIFO empty, no token; "x;" -> {0,1}.
- With ID_UNDERSCORE_EN, "_a1;" -> {0,3}; without, "_a1;" -> {1,2}.
